analog_sar_readout: RTL and testbench

Successive-approximation readout controller for the analog student area, the return path of the analog control interface. It drives a trial DAC code and a sample/hold enable into the analog block, reads back that block's asynchronous comparator output, and resolves a `DATA_W`-bit result for the digital side (PMOD GPO, status registers). The analog block and the pad mapping sit outside this module; this block is pure digital control.

---
 rtl/analog_sar_pkg.sv | 24 ++
 rtl/sync_ff.sv | 31 +++
 rtl/analog_sar_readout.sv | 134 +++++++++++++
 tb/tb_analog_sar_readout.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/analog_sar_pkg.sv
// ============================================================================
// Module  : analog_sar_pkg
// Brief   : Shared types and sizing helpers for the SAR readout controller.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package analog_sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAMPLE = 2'd1,
        ST_CONV   = 2'd2,
        ST_DONE   = 2'd3
    } sar_state_e;

    // The bit window (settle + sync) is always the longest hold, so it sizes the counter.
    function automatic int sar_cnt_width(input int settle, input int sync);
        return $clog2(settle + sync + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_ff.sv
// ============================================================================
// Module  : sync_ff
// Brief   : Multi-stage 1-bit synchronizer with synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/analog_sar_readout.sv
// ============================================================================
// Module  : analog_sar_readout
// Brief   : SAR readout controller driving the analog DAC / sample-hold.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module analog_sar_readout
    import analog_sar_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic              clk_in,
    input  logic              reset_int,
    input  logic              start_in,
    input  logic              comp_in,
    output logic              sample_en,
    output logic [DATA_W-1:0] dac_code,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic              result_valid
);

    localparam int CNT_W = sar_cnt_width(SETTLE_CYCLES, SYNC_STAGES);
    localparam int BIT_W = $clog2(DATA_W);

    localparam logic [CNT_W-1:0]  c_SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  c_WIN_LOAD    = CNT_W'(SETTLE_CYCLES + SYNC_STAGES - 1);
    localparam logic [BIT_W-1:0]  c_MSB         = BIT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] c_ONE         = DATA_W'(1);

    logic              w_start_s;
    logic              w_comp_s;
    logic              r_start_prev;
    logic              r_start_edge;
    sar_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [BIT_W-1:0]  r_bit;
    logic [DATA_W-1:0] w_trial_bit;
    logic [DATA_W-1:0] w_decided;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_start (
        .clk (clk_in),
        .rst (reset_int),
        .i_d (start_in),
        .o_q (w_start_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_comp (
        .clk (clk_in),
        .rst (reset_int),
        .i_d (comp_in),
        .o_q (w_comp_s)
    );

    // Trial bit under test; a low comparator means the code overshot, so drop it.
    assign w_trial_bit = c_ONE << r_bit;
    assign w_decided   = w_comp_s ? dac_code : (dac_code & ~w_trial_bit);

    // Edge history runs in every state so a level held through a conversion cannot retrigger.
    always_ff @(posedge clk_in) begin
        if (reset_int) begin
            r_start_prev <= 1'b0;
            r_start_edge <= 1'b0;
        end else begin
            r_start_prev <= w_start_s;
            r_start_edge <= w_start_s & ~r_start_prev;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_int) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            sample_en    <= 1'b0;
            dac_code     <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    result_valid <= 1'b0;
                    if (r_start_edge) begin
                        r_state   <= ST_SAMPLE;
                        r_cnt     <= c_SETTLE_LOAD;
                        sample_en <= 1'b1;
                        dac_code  <= '0;
                        busy      <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (r_cnt == '0) begin
                        r_state   <= ST_CONV;
                        r_cnt     <= c_WIN_LOAD;
                        r_bit     <= c_MSB;
                        sample_en <= 1'b0;
                        dac_code  <= c_ONE << c_MSB;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_CONV: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else if (r_bit == '0) begin
                        r_state      <= ST_DONE;
                        result       <= w_decided;
                        result_valid <= 1'b1;
                        dac_code     <= '0;
                        busy         <= 1'b0;
                    end else begin
                        r_cnt    <= c_WIN_LOAD;
                        r_bit    <= r_bit - BIT_W'(1);
                        dac_code <= w_decided | (w_trial_bit >> 1);
                    end
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    result_valid <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_analog_sar_readout.sv
// ============================================================================
// Module  : tb_analog_sar_readout
// Brief   : Directed self-checking bench for analog_sar_readout (two configs).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_analog_sar_readout;

    logic       clk;
    logic       rst;
    logic       start_a, start_b;
    logic [7:0] vin_a;
    logic [3:0] vin_b;

    logic       sample_en_a, busy_a, rv_a;
    logic [7:0] dac_a, result_a;
    logic       sample_en_b, busy_b, rv_b;
    logic [3:0] dac_b, result_b;
    logic       comp_a, comp_b;

    int tests_run = 0;
    int tests_failed = 0;
    int rv_cnt_a = 0;
    logic [7:0] dac_seq [0:2];

    // Behavioural comparator: 1 when the analog input is at or above the DAC code.
    assign comp_a = (vin_a >= dac_a);
    assign comp_b = (vin_b >= dac_b);

    analog_sar_readout #(.DATA_W(8), .SETTLE_CYCLES(4), .SYNC_STAGES(2)) u_dut_a (
        .clk_in       (clk),
        .reset_int    (rst),
        .start_in     (start_a),
        .comp_in      (comp_a),
        .sample_en    (sample_en_a),
        .dac_code     (dac_a),
        .busy         (busy_a),
        .result       (result_a),
        .result_valid (rv_a)
    );

    analog_sar_readout #(.DATA_W(4), .SETTLE_CYCLES(1), .SYNC_STAGES(3)) u_dut_b (
        .clk_in       (clk),
        .reset_int    (rst),
        .start_in     (start_b),
        .comp_in      (comp_b),
        .sample_en    (sample_en_b),
        .dac_code     (dac_b),
        .busy         (busy_b),
        .result       (result_b),
        .result_valid (rv_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rv_a) rv_cnt_a++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One start pulse on the selected DUT; checks latency, busy length, result and pulse width.
    task automatic run_conv(input int sel, input logic [7:0] v, input logic [7:0] exp,
                            input int exp_busy, input string tag);
        int lat;
        int nb;
        int nd;
        logic [7:0] last;
        lat = 0;
        nd = 0;
        last = 8'h00;
        if (sel == 0) vin_a = v; else vin_b = v[3:0];
        repeat (2) @(negedge clk);
        if (sel == 0) start_a = 1'b1; else start_b = 1'b1;
        while (!(sel == 0 ? busy_a : busy_b) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, lat, (sel == 0) ? 4 : 5);
        nb = 1;
        while ((sel == 0 ? busy_a : busy_b) && nb < 300) begin
            if (sel == 0 && !sample_en_a && dac_a != last && nd < 3) begin
                dac_seq[nd] = dac_a;
                nd++;
                last = dac_a;
            end
            if (nb == 4) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            @(negedge clk);
            if (sel == 0 ? busy_a : busy_b) nb++;
        end
        check({tag, "_busy_cycles"}, nb, exp_busy);
        check({tag, "_valid"}, (sel == 0) ? rv_a : rv_b, 1'b1);
        check({tag, "_result"}, (sel == 0) ? result_a : {4'h0, result_b}, exp);
        @(negedge clk);
        check({tag, "_valid_pulse"}, (sel == 0) ? rv_a : rv_b, 1'b0);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    initial begin
        int base;
        int guard;
        rst = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        vin_a = 8'h00;
        vin_b = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_outputs_a", {sample_en_a, busy_a, rv_a, dac_a, result_a}, 0);
        check("rst_outputs_b", {sample_en_b, busy_b, rv_b, dac_b, result_b}, 0);
        rst = 1'b0;
        @(negedge clk);

        run_conv(0, 8'hA5, 8'hA5, 52, "a5");
        check("a5_dac_seq0", dac_seq[0], 8'h80);
        check("a5_dac_seq1", dac_seq[1], 8'hC0);
        check("a5_dac_seq2", dac_seq[2], 8'hA0);
        run_conv(0, 8'h00, 8'h00, 52, "zero");
        run_conv(0, 8'hFF, 8'hFF, 52, "full");
        check("no_x", $isunknown({sample_en_a, busy_a, rv_a, dac_a, result_a}), 1'b0);

        // Level held high for 200 cycles must convert once only.
        base = rv_cnt_a;
        vin_a = 8'h5A;
        start_a = 1'b1;
        repeat (200) @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        check("held_one_valid", rv_cnt_a - base, 1);
        check("held_result", result_a, 8'h5A);

        // Extra start pulses while busy are ignored.
        base = rv_cnt_a;
        vin_a = 8'h33;
        start_a = 1'b1;
        guard = 0;
        while (!busy_a && guard < 20) begin @(negedge clk); guard++; end
        start_a = 1'b0;
        for (int p = 0; p < 4; p++) begin
            repeat (8) @(negedge clk);
            start_a = 1'b1;
            repeat (3) @(negedge clk);
            start_a = 1'b0;
        end
        guard = 0;
        while (busy_a && guard < 100) begin @(negedge clk); guard++; end
        repeat (70) @(negedge clk);
        check("busy_pulse_one_valid", rv_cnt_a - base, 1);
        check("busy_pulse_result", result_a, 8'h33);
        check("busy_pulse_idle", busy_a, 1'b0);

        // Reset during the 4th bit window of a 0x3C conversion.
        vin_a = 8'h3C;
        start_a = 1'b1;
        guard = 0;
        while (!busy_a && guard < 20) begin @(negedge clk); guard++; end
        start_a = 1'b0;
        repeat (23) @(negedge clk);
        check("mid_busy_before_rst", busy_a, 1'b1);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_outputs", {sample_en_a, busy_a, rv_a, dac_a, result_a}, 0);
        rst = 1'b0;
        @(negedge clk);
        run_conv(0, 8'h3C, 8'h3C, 52, "restart");

        run_conv(1, 8'h09, 8'h09, 17, "w4_nine");
        run_conv(1, 8'h00, 8'h00, 17, "w4_zero");
        run_conv(1, 8'h0F, 8'h0F, 17, "w4_full");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
